// File: rtl/dv_debounce_pkg.sv
// rtl/dv_debounce_pkg.sv - shared state encoding for the dv pushbutton debouncer
package dv_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    function automatic logic is_pressed_level(input state_t st);
        return (st == PRESSED) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous board inputs, resets to 0
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/dv_debounce.sv
// rtl/dv_debounce.sv - debounces a raw pushbutton into one single-cycle dv pulse per press
module dv_debounce
    import dv_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       dv,
    output logic       btn_level,
    output logic [1:0] stateLed
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic                 dv_nx;
    logic                 btn_in;
    logic                 s;

    // Normalise polarity so that 1 always means pressed from here on.
    assign btn_in = btn_raw ^ BTN_ACTIVE_LOW;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
            dv    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dv    <= dv_nx;
        end
    end

    // The counter restarts on every state change, so it can never pass CNT_MAX.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dv_nx    = 1'b0;
        case (state)
            RELEASED: begin
                cnt_nx = '0;
                if (s) state_nx = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                    dv_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                cnt_nx = '0;
                if (!s) state_nx = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = RELEASED;
                cnt_nx   = '0;
                dv_nx    = 1'b0;
            end
        endcase
    end

    assign btn_level = is_pressed_level(state);
    assign stateLed  = state;

endmodule

// File: tb/tb_dv_debounce.sv
// tb/tb_dv_debounce.sv - scoreboard bench for dv_debounce in both pin polarities
module tb_dv_debounce;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn   = 1'b0;
    logic       btn_n;
    logic       dv_h, lvl_h, dv_l, lvl_l;
    logic [1:0] st_h, st_l;

    assign btn_n = ~btn;

    always #5 clock = ~clock;

    dv_debounce #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(3), .BTN_ACTIVE_LOW(1'b0)) dut_h (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn),
        .dv        (dv_h),
        .btn_level (lvl_h),
        .stateLed  (st_h)
    );

    dv_debounce #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(3), .BTN_ACTIVE_LOW(1'b1)) dut_l (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_n),
        .dv        (dv_l),
        .btn_level (lvl_l),
        .stateLed  (st_l)
    );

    // Reference: the debounced level flips once the delayed pin has disagreed
    // with it for N+1 consecutive samples; stateLed is {level, disagreement pending}.
    int   cyc = 0;
    logic d1 = 1'b0, d2 = 1'b0;
    logic level = 1'b0;
    int   run = 0;
    logic       exp_level = 1'b0;
    logic [1:0] exp_state = 2'd0;
    int   q_h[$];
    int   q_l[$];

    int   n_vec  = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    task automatic model_reset();
        d1 = 1'b0; d2 = 1'b0; level = 1'b0; run = 0;
        exp_level = 1'b0; exp_state = 2'd0;
        q_h.delete(); q_l.delete();
    endtask

    task automatic model_edge();
        logic seen;
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            seen = d2;
            d2 = d1;
            d1 = btn;
            if (seen != level) begin
                run++;
                if (run == N + 1) begin
                    level = seen;
                    run = 0;
                    if (level) begin
                        q_h.push_back(cyc);
                        q_l.push_back(cyc);
                    end
                end
            end else begin
                run = 0;
            end
            exp_level = level;
            exp_state = {level, run != 0};
        end
    endtask

    task automatic step(input logic b);
        btn = b;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic check_dv(input string name, input logic dv, inout int q[$]);
        if (q.size() > 0 && q[0] < cyc) begin
            check({name, "_missing"}, 0, 1);
            void'(q.pop_front());
        end
        if (dv) begin
            if (q.size() > 0 && q[0] == cyc) begin
                check(name, cyc, cyc);
                void'(q.pop_front());
            end else begin
                check({name, "_unexpected"}, 1, 0);
            end
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            check("level_h", lvl_h, exp_level);
            check("state_h", st_h, exp_state);
            check("level_l", lvl_l, exp_level);
            check("state_l", st_l, exp_state);
            check_dv("dv_h", dv_h, q_h);
            check_dv("dv_l", dv_l, q_l);
        end
    end

    initial begin
        model_reset();
        #12;
        check("reset_dv_h", dv_h, 0);
        check("reset_level_h", lvl_h, 0);
        check("reset_state_h", st_h, 0);
        check("reset_dv_l", dv_l, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        started = 1'b1;

        hold(1'b0, 3);
        hold(1'b1, 20);
        hold(1'b0, 10);
        hold(1'b1, 3);
        hold(1'b0, 10);
        for (int k = 0; k < 2; k++) begin
            step(1'b1); step(1'b0); step(1'b1); step(1'b0);
            hold(1'b1, 12);
            step(1'b0); step(1'b1); step(1'b0); step(1'b1);
            hold(1'b0, 12);
        end
        hold(1'b1, 1000);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 12);

        // Reset while in PRESS_WAIT with cnt=2, button kept pressed through release.
        hold(1'b1, 5);
        reset = 1'b1;
        model_reset();
        #1;
        check("midreset_dv", dv_h | dv_l, 0);
        check("midreset_level", lvl_h | lvl_l, 0);
        check("midreset_state", st_h | st_l, 0);
        hold(1'b1, 2);
        reset = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 10);

        for (int seg = 0; seg < 80; seg++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 30) : $urandom_range(1, 6);
            hold(1'(seg & 1), len);
        end
        hold(1'b0, 20);

        check("pending_h", q_h.size(), 0);
        check("pending_l", q_l.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
